pipe_stage_regs: RTL and testbench
==================================

Name: pipe_stage_regs

Overview:
- Sequential counterpart of the hazard unit: the PC register, IF/ID register and ID/EX register.
- Applies the hazard unit's StallF/StallD/FlushD/FlushE to the five-stage RV32I pipeline.
- Tracks per-stage valid bits so bubbles are explicit.
- Keeps saturating stall/flush event counters for the core's debug/perf readout.

Parameters:
- XLEN, 32, datapath width.
- RESET_PC, 32'h0000_0000, PCF value after reset.
- NOP_INSTR, 32'h0000_0013, instruction loaded into InstrD on reset/flush (addi x0,x0,0).
- CNT_W, 16, width of each event counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- PCNextF  in  XLEN  next PC from fetch mux.
- InstrF  in  32  fetched instruction.
- PCPlus4F  in  XLEN  PCF+4.
- StallF  in  1  hold PCF.
- StallD  in  1  hold IF/ID.
- FlushD  in  1  clear IF/ID to bubble.
- FlushE  in  1  clear ID/EX to bubble.
- RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  in  1 each  decode controls.
- ResultSrcD  in  2  decode result select.
- ALUControlD  in  3  decode ALU op.
- RD1D, RD2D, ImmExtD  in  XLEN  register file and immediate values.
- Rs1D, Rs2D, RdD  in  5  register indices (taken from the D-stage outputs below by the decode stage).
- PCF  out  XLEN  current fetch PC.
- InstrD, PCD, PCPlus4D  out  32/XLEN/XLEN  IF/ID contents.
- ValidD  out  1  IF/ID holds a real instruction.
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, PCE, PCPlus4E  out  matching widths  ID/EX contents.
- ValidE  out  1  ID/EX holds a real instruction.
- StallCnt  out  CNT_W  cycles with StallF=1.
- FlushCnt  out  CNT_W  cycles with FlushE=1.

Behaviour:
- All state updates on the rising clk edge. Outputs are registered, with 1-cycle latency.
- rst (synchronous, highest priority):
  - PCF=RESET_PC.
  - InstrD=NOP_INSTR.
  - PCD=PCPlus4D=0.
  - ValidD=0.
  - All E outputs=0, ValidE=0.
  - StallCnt=FlushCnt=0.
- PC register:
  - StallF=1: PCF holds.
  - Otherwise PCF<=PCNextF.
- IF/ID priority is FlushD > StallD > load.
  - Flush: InstrD<=NOP_INSTR, PCD<=0, PCPlus4D<=0, ValidD<=0.
  - Stall: all fields hold, including ValidD.
  - Load: InstrF/PCF/PCPlus4F captured, ValidD<=1.
- FlushD with StallD both set (load-use in D while a taken branch is in E): flush wins.
- ID/EX:
  - FlushE=1: all control fields (RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE) <=0 and ValidE<=0.
  - On flush, data/index fields (RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, PCE, PCPlus4E) also <=0, so the hazard unit never sees a stale RdE.
  - Otherwise all D inputs are captured and ValidE<=ValidD.
  - There is no stall on ID/EX: a load-use stall is expressed as FlushE.
- Write enables are gated: when loading ID/EX from a bubble (ValidD=0), RegWriteE and MemWriteE are forced to 0 regardless of the decode inputs.
- Counters:
  - StallCnt increments on each cycle with StallF=1.
  - FlushCnt increments on each cycle with FlushE=1.
  - Both saturate at all-ones (no wrap).
  - Counters are not affected by the other hazard signals.
- Reset asserted mid-stall or mid-flush: reset overrides. The following cycle behaves as the first fetch from RESET_PC.
- Combinational inputs must be stable before the edge. The block has no combinational input-to-output paths.

Decomposition:
- Shared package (riscv_pkg): XLEN, NOP_INSTR, the ResultSrc encodings (00 ALU, 01 mem, 10 PC+4, 11 imm), and the ALUControl width constant.
- One sub-module is natural: sat_counter (CNT_W-bit, synchronous clear, enable, saturating).
  - Instantiated twice, for StallCnt and FlushCnt.
- The pipeline registers stay in the top module.

Test Plan:
- Reset then free-run with PCNextF=PCF+4 and InstrF=32'h00500093:
  - 1 cycle after reset release: PCF=4, InstrD=32'h00500093, ValidD=1.
  - ValidE=1 one cycle later.
- Load-use, with StallF=StallD=FlushE=1 for one cycle at PCF=8:
  - PCF stays 8, InstrD held, ValidE=0, RegWriteE=0, RdE=0.
  - StallCnt=1, FlushCnt=1.
- Taken branch, with FlushD=FlushE=1 and PCNextF=32'h40:
  - Next cycle: PCF=32'h40, InstrD=32'h00000013, ValidD=0, ValidE=0.
  - One cycle later: ValidE=0 propagated, with RegWriteE=0 even though RegWriteD=1.
- FlushD and StallD together with StallF=1:
  - InstrD=NOP_INSTR, ValidD=0 (flush wins), PCF held.
- Saturation with CNT_W=4: hold StallF=1 for 20 cycles.
  - StallCnt reaches 15 and stays at 15.
- Reset asserted while StallF=1 and FlushE=1:
  - Next cycle: PCF=RESET_PC, all valids 0, both counters 0.

Source files
------------

// File: rtl/pipe_stage_regs_pkg.sv
// Shared constants and types for the RV32I pipeline stage registers.
package pipe_stage_regs_pkg;

  localparam int unsigned XLEN       = 32;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam int unsigned ALU_CTRL_W = 3;

  typedef enum logic [1:0] {
    ResSrcAlu = 2'b00,
    ResSrcMem = 2'b01,
    ResSrcPc4 = 2'b10,
    ResSrcImm = 2'b11
  } result_src_e;

  // Control bundle carried from decode into execute.
  typedef struct packed {
    logic                  reg_write;
    logic                  mem_write;
    logic                  jump;
    logic                  branch;
    logic                  alu_src;
    result_src_e           result_src;
    logic [ALU_CTRL_W-1:0] alu_control;
  } ex_ctrl_t;

endpackage

// File: rtl/pipe_stage_regs_if.sv
// Fetch/decode inputs, hazard controls and registered stage outputs of the pipeline registers.
interface pipe_stage_regs_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
);
  import pipe_stage_regs_pkg::*;

  logic [XLEN-1:0]       PCNextF, PCPlus4F;
  logic [31:0]           InstrF;
  logic                  StallF, StallD, FlushD, FlushE;
  logic                  RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0]            ResultSrcD;
  logic [ALU_CTRL_W-1:0] ALUControlD;
  logic [XLEN-1:0]       RD1D, RD2D, ImmExtD;
  logic [4:0]            Rs1D, Rs2D, RdD;

  logic [XLEN-1:0]       PCF;
  logic [31:0]           InstrD;
  logic [XLEN-1:0]       PCD, PCPlus4D;
  logic                  ValidD;
  logic                  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]            ResultSrcE;
  logic [ALU_CTRL_W-1:0] ALUControlE;
  logic [XLEN-1:0]       RD1E, RD2E, ImmExtE;
  logic [4:0]            Rs1E, Rs2E, RdE;
  logic [XLEN-1:0]       PCE, PCPlus4E;
  logic                  ValidE;
  logic [CNT_W-1:0]      StallCnt, FlushCnt;

  modport master (
    output PCNextF, PCPlus4F, InstrF, StallF, StallD, FlushD, FlushE,
           RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD,
           RD1D, RD2D, ImmExtD, Rs1D, Rs2D, RdD,
    input  PCF, InstrD, PCD, PCPlus4D, ValidD,
           RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
           RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, PCE, PCPlus4E, ValidE,
           StallCnt, FlushCnt
  );

  modport slave (
    input  PCNextF, PCPlus4F, InstrF, StallF, StallD, FlushD, FlushE,
           RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD,
           RD1D, RD2D, ImmExtD, Rs1D, Rs2D, RdD,
    output PCF, InstrD, PCD, PCPlus4D, ValidD,
           RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
           RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, PCE, PCPlus4E, ValidE,
           StallCnt, FlushCnt
  );

endinterface

// File: rtl/pipe_stage_regs_sat_counter.sv
// Event counter with synchronous clear that sticks at all-ones instead of wrapping.
module pipe_stage_regs_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_regs.sv
// PC, IF/ID and ID/EX registers applying stall/flush, with explicit valid bits and event counters.
module pipe_stage_regs #(
  parameter int unsigned     XLEN      = pipe_stage_regs_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = pipe_stage_regs_pkg::NOP_INSTR,
  parameter int unsigned     CNT_W     = 16
) (
  input logic              clk,
  input logic              rst,
  pipe_stage_regs_if.slave io_bus
);
  import pipe_stage_regs_pkg::*;

  logic [XLEN-1:0] r_pc_f;
  logic [31:0]     r_instr_d;
  logic [XLEN-1:0] r_pc_d, r_pc_plus4_d;
  logic            r_valid_d;

  ex_ctrl_t        r_ctrl_e, w_ctrl_d;
  logic [XLEN-1:0] r_rd1_e, r_rd2_e, r_imm_e, r_pc_e, r_pc_plus4_e;
  logic [4:0]      r_rs1_e, r_rs2_e, r_rd_e;
  logic            r_valid_e;

  logic [CNT_W-1:0] w_stall_cnt, w_flush_cnt;

  // A bubble leaving decode must never write the register file or memory.
  always_comb begin
    w_ctrl_d.reg_write   = io_bus.RegWriteD & r_valid_d;
    w_ctrl_d.mem_write   = io_bus.MemWriteD & r_valid_d;
    w_ctrl_d.jump        = io_bus.JumpD;
    w_ctrl_d.branch      = io_bus.BranchD;
    w_ctrl_d.alu_src     = io_bus.ALUSrcD;
    w_ctrl_d.result_src  = result_src_e'(io_bus.ResultSrcD);
    w_ctrl_d.alu_control = io_bus.ALUControlD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_f       <= RESET_PC;
      r_instr_d    <= NOP_INSTR;
      r_pc_d       <= '0;
      r_pc_plus4_d <= '0;
      r_valid_d    <= 1'b0;
      r_ctrl_e     <= '0;
      r_rd1_e      <= '0;
      r_rd2_e      <= '0;
      r_imm_e      <= '0;
      r_rs1_e      <= '0;
      r_rs2_e      <= '0;
      r_rd_e       <= '0;
      r_pc_e       <= '0;
      r_pc_plus4_e <= '0;
      r_valid_e    <= 1'b0;
    end else begin
      if (!io_bus.StallF) r_pc_f <= io_bus.PCNextF;

      if (io_bus.FlushD) begin
        r_instr_d    <= NOP_INSTR;
        r_pc_d       <= '0;
        r_pc_plus4_d <= '0;
        r_valid_d    <= 1'b0;
      end else if (!io_bus.StallD) begin
        r_instr_d    <= io_bus.InstrF;
        r_pc_d       <= r_pc_f;
        r_pc_plus4_d <= io_bus.PCPlus4F;
        r_valid_d    <= 1'b1;
      end

      // Data fields are cleared too so hazard detection never matches a stale RdE.
      if (io_bus.FlushE) begin
        r_ctrl_e     <= '0;
        r_rd1_e      <= '0;
        r_rd2_e      <= '0;
        r_imm_e      <= '0;
        r_rs1_e      <= '0;
        r_rs2_e      <= '0;
        r_rd_e       <= '0;
        r_pc_e       <= '0;
        r_pc_plus4_e <= '0;
        r_valid_e    <= 1'b0;
      end else begin
        r_ctrl_e     <= w_ctrl_d;
        r_rd1_e      <= io_bus.RD1D;
        r_rd2_e      <= io_bus.RD2D;
        r_imm_e      <= io_bus.ImmExtD;
        r_rs1_e      <= io_bus.Rs1D;
        r_rs2_e      <= io_bus.Rs2D;
        r_rd_e       <= io_bus.RdD;
        r_pc_e       <= r_pc_d;
        r_pc_plus4_e <= r_pc_plus4_d;
        r_valid_e    <= r_valid_d;
      end
    end
  end

  pipe_stage_regs_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .i_clr (rst),
    .i_en  (io_bus.StallF),
    .o_cnt (w_stall_cnt)
  );

  pipe_stage_regs_sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .i_clr (rst),
    .i_en  (io_bus.FlushE),
    .o_cnt (w_flush_cnt)
  );

  assign io_bus.PCF         = r_pc_f;
  assign io_bus.InstrD      = r_instr_d;
  assign io_bus.PCD         = r_pc_d;
  assign io_bus.PCPlus4D    = r_pc_plus4_d;
  assign io_bus.ValidD      = r_valid_d;
  assign io_bus.RegWriteE   = r_ctrl_e.reg_write;
  assign io_bus.MemWriteE   = r_ctrl_e.mem_write;
  assign io_bus.JumpE       = r_ctrl_e.jump;
  assign io_bus.BranchE     = r_ctrl_e.branch;
  assign io_bus.ALUSrcE     = r_ctrl_e.alu_src;
  assign io_bus.ResultSrcE  = r_ctrl_e.result_src;
  assign io_bus.ALUControlE = r_ctrl_e.alu_control;
  assign io_bus.RD1E        = r_rd1_e;
  assign io_bus.RD2E        = r_rd2_e;
  assign io_bus.ImmExtE     = r_imm_e;
  assign io_bus.Rs1E        = r_rs1_e;
  assign io_bus.Rs2E        = r_rs2_e;
  assign io_bus.RdE         = r_rd_e;
  assign io_bus.PCE         = r_pc_e;
  assign io_bus.PCPlus4E    = r_pc_plus4_e;
  assign io_bus.ValidE      = r_valid_e;
  assign io_bus.StallCnt    = w_stall_cnt;
  assign io_bus.FlushCnt    = w_flush_cnt;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed scoreboard bench: expectations queued with each step, checked one cycle later.
module tb_pipe_stage_regs;

  localparam int unsigned CNT_W = 4;

  logic clk;
  logic rst;

  pipe_stage_regs_if #(.XLEN(32), .CNT_W(CNT_W)) bus ();

  pipe_stage_regs #(
    .XLEN      (32),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013),
    .CNT_W     (CNT_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef enum int {
    SelPcf, SelInstrD, SelPcD, SelValidD, SelValidE, SelRegWriteE,
    SelMemWriteE, SelRdE, SelStallCnt, SelFlushCnt
  } sel_e;

  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] want;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic [31:0] pc_m;

  function automatic logic [31:0] observe(sel_e s);
    case (s)
      SelPcf:       return bus.PCF;
      SelInstrD:    return bus.InstrD;
      SelPcD:       return bus.PCD;
      SelValidD:    return {31'd0, bus.ValidD};
      SelValidE:    return {31'd0, bus.ValidE};
      SelRegWriteE: return {31'd0, bus.RegWriteE};
      SelMemWriteE: return {31'd0, bus.MemWriteE};
      SelRdE:       return {27'd0, bus.RdE};
      SelStallCnt:  return {{(32-CNT_W){1'b0}}, bus.StallCnt};
      SelFlushCnt:  return {{(32-CNT_W){1'b0}}, bus.FlushCnt};
      default:      return 'x;
    endcase
  endfunction

  task automatic expect_val(input string tag, input sel_e s, input logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.sel  = s;
    e.want = v;
    q.push_back(e);
  endtask

  task automatic drive(input logic r, input logic sf, input logic sd, input logic fd,
                       input logic fe, input logic [31:0] pc_next);
    rst            = r;
    bus.StallF     = sf;
    bus.StallD     = sd;
    bus.FlushD     = fd;
    bus.FlushE     = fe;
    bus.PCNextF    = pc_next;
    bus.PCPlus4F   = pc_m + 32'd4;
  endtask

  task automatic cycle();
    exp_t e;
    logic [31:0] obs;
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      e   = q.pop_front();
      obs = observe(e.sel);
      n_cmp++;
      assert (obs === e.want)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.want);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pc_m            = 32'h0;
    bus.InstrF      = 32'h0050_0093;
    bus.RegWriteD   = 1'b1;
    bus.MemWriteD   = 1'b0;
    bus.JumpD       = 1'b0;
    bus.BranchD     = 1'b0;
    bus.ALUSrcD     = 1'b1;
    bus.ResultSrcD  = 2'b00;
    bus.ALUControlD = 3'b000;
    bus.RD1D        = 32'h1111_1111;
    bus.RD2D        = 32'h2222_2222;
    bus.ImmExtD     = 32'h5;
    bus.Rs1D        = 5'd0;
    bus.Rs2D        = 5'd5;
    bus.RdD         = 5'd1;

    // Reset state
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4);
    expect_val("rst_pcf", SelPcf, 32'h0);
    expect_val("rst_instrd", SelInstrD, 32'h13);
    expect_val("rst_validd", SelValidD, 32'd0);
    expect_val("rst_valide", SelValidE, 32'd0);
    expect_val("rst_regwre", SelRegWriteE, 32'd0);
    expect_val("rst_stallcnt", SelStallCnt, 32'd0);
    expect_val("rst_flushcnt", SelFlushCnt, 32'd0);
    cycle();

    // First fetch
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4);
    expect_val("f1_pcf", SelPcf, 32'h4);
    expect_val("f1_instrd", SelInstrD, 32'h0050_0093);
    expect_val("f1_validd", SelValidD, 32'd1);
    expect_val("f1_valide", SelValidE, 32'd0);
    expect_val("f1_regwre_bubble", SelRegWriteE, 32'd0);
    cycle();
    pc_m = 32'h4;

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8);
    expect_val("f2_pcf", SelPcf, 32'h8);
    expect_val("f2_pcd", SelPcD, 32'h4);
    expect_val("f2_valide", SelValidE, 32'd1);
    expect_val("f2_regwre", SelRegWriteE, 32'd1);
    expect_val("f2_rde", SelRdE, 32'd1);
    cycle();
    pc_m = 32'h8;

    // Load-use stall at PCF=8
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hC);
    expect_val("lu_pcf_hold", SelPcf, 32'h8);
    expect_val("lu_instrd_hold", SelInstrD, 32'h0050_0093);
    expect_val("lu_pcd_hold", SelPcD, 32'h4);
    expect_val("lu_validd_hold", SelValidD, 32'd1);
    expect_val("lu_valide", SelValidE, 32'd0);
    expect_val("lu_regwre", SelRegWriteE, 32'd0);
    expect_val("lu_rde", SelRdE, 32'd0);
    expect_val("lu_stallcnt", SelStallCnt, 32'd1);
    expect_val("lu_flushcnt", SelFlushCnt, 32'd1);
    cycle();

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hC);
    expect_val("rel_pcf", SelPcf, 32'hC);
    expect_val("rel_pcd", SelPcD, 32'h8);
    expect_val("rel_valide", SelValidE, 32'd1);
    expect_val("rel_stallcnt", SelStallCnt, 32'd1);
    cycle();
    pc_m = 32'hC;

    // Taken branch redirect to 0x40
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40);
    expect_val("br_pcf", SelPcf, 32'h40);
    expect_val("br_instrd", SelInstrD, 32'h13);
    expect_val("br_validd", SelValidD, 32'd0);
    expect_val("br_pcd", SelPcD, 32'h0);
    expect_val("br_valide", SelValidE, 32'd0);
    expect_val("br_flushcnt", SelFlushCnt, 32'd2);
    cycle();
    pc_m = 32'h40;

    bus.MemWriteD = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h44);
    expect_val("brn_pcf", SelPcf, 32'h44);
    expect_val("brn_validd", SelValidD, 32'd1);
    expect_val("brn_valide", SelValidE, 32'd0);
    expect_val("brn_regwre_gated", SelRegWriteE, 32'd0);
    expect_val("brn_memwre_gated", SelMemWriteE, 32'd0);
    expect_val("brn_rde", SelRdE, 32'd1);
    cycle();
    pc_m = 32'h44;

    // FlushD and StallD together with StallF: flush wins, PC held
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h48);
    expect_val("fs_pcf", SelPcf, 32'h44);
    expect_val("fs_instrd", SelInstrD, 32'h13);
    expect_val("fs_validd", SelValidD, 32'd0);
    expect_val("fs_valide", SelValidE, 32'd1);
    expect_val("fs_memwre", SelMemWriteE, 32'd1);
    expect_val("fs_stallcnt", SelStallCnt, 32'd2);
    cycle();
    bus.MemWriteD = 1'b0;

    // Saturation: StallF held for 20 cycles
    for (int i = 1; i <= 20; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h48);
      expect_val("sat_stallcnt", SelStallCnt, (2 + i > 15) ? 32'd15 : 32'(2 + i));
      expect_val("sat_pcf", SelPcf, 32'h44);
      if (i == 20) expect_val("sat_flushcnt", SelFlushCnt, 32'd2);
      cycle();
    end

    // Reset overrides active stall and flush
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h48);
    expect_val("rr_pcf", SelPcf, 32'h0);
    expect_val("rr_validd", SelValidD, 32'd0);
    expect_val("rr_valide", SelValidE, 32'd0);
    expect_val("rr_stallcnt", SelStallCnt, 32'd0);
    expect_val("rr_flushcnt", SelFlushCnt, 32'd0);
    cycle();
    pc_m = 32'h0;

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4);
    expect_val("rr_f1_pcf", SelPcf, 32'h4);
    expect_val("rr_f1_validd", SelValidD, 32'd1);
    expect_val("rr_f1_pcd", SelPcD, 32'h0);
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
